// File: rtl/mips_ext_pkg.sv
// Shared types and default widths for the MIPS load/immediate extender.
package mips_ext_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int IMM_W_DEF  = 16;

  typedef enum logic [3:0] {
    EXT_SIMM = 4'd0,
    EXT_ZIMM = 4'd1,
    EXT_LUI  = 4'd2,
    EXT_LB   = 4'd3,
    EXT_LBU  = 4'd4,
    EXT_LH   = 4'd5,
    EXT_LHU  = 4'd6,
    EXT_LW   = 4'd7,
    EXT_LWL  = 4'd8,
    EXT_LWR  = 4'd9
  } ext_mode_t;

endpackage

// File: rtl/ext_datapath.sv
// Combinational immediate/load extension and LWL/LWR merge; zero latency, no flow control.
module ext_datapath
  import mips_ext_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMM_W  = IMM_W_DEF
) (
  input  logic [3:0]                    in_mode,
  input  logic [IMM_W-1:0]              in_imm,
  input  logic [DATA_W-1:0]             in_word,
  input  logic [$clog2(DATA_W/8)-1:0]   in_offset,
  input  logic [DATA_W-1:0]             in_rt_old,
  output logic [DATA_W-1:0]             res_data,
  output logic                          res_err
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);

  // lo_sh = 8*k (LWR / lane select), hi_sh = 8*(L-1-k) (LWL)
  logic [OFF_W+2:0]  lo_sh;
  logic [OFF_W+2:0]  hi_sh;
  logic [DATA_W-1:0] shr;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;

  assign lo_sh  = {in_offset, 3'b000};
  assign hi_sh  = {OFF_W'(LANES - 1) - in_offset, 3'b000};
  assign shr    = in_word >> lo_sh;
  assign lane_b = shr[7:0];
  assign lane_h = shr[15:0];

  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (in_mode)
      EXT_SIMM: res_data = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
      EXT_ZIMM: res_data = {{(DATA_W-IMM_W){1'b0}}, in_imm};
      EXT_LUI:  res_data = {{(DATA_W-IMM_W){1'b0}}, in_imm} << IMM_W;
      EXT_LB:   res_data = {{(DATA_W-8){lane_b[7]}}, lane_b};
      EXT_LBU:  res_data = {{(DATA_W-8){1'b0}}, lane_b};
      EXT_LH, EXT_LHU: begin
        if (in_offset[0]) res_err = 1'b1;
        else res_data = {{(DATA_W-16){lane_h[15] & (in_mode == EXT_LH)}}, lane_h};
      end
      EXT_LW: begin
        if (in_offset != '0) res_err = 1'b1;
        else res_data = in_word;
      end
      EXT_LWL:  res_data = (in_word << hi_sh) | (in_rt_old & ~({DATA_W{1'b1}} << hi_sh));
      EXT_LWR:  res_data = shr | (in_rt_old & ~({DATA_W{1'b1}} >> lo_sh));
      default:  res_err = 1'b1;
    endcase
    if (res_err) res_data = '0;
  end

endmodule

// File: rtl/data_extender.sv
// Extender with a registered 2-entry skid buffer: 1-cycle latency;
// in_ready depends only on skid occupancy, never on out_ready.
module data_extender
  import mips_ext_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMM_W  = IMM_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_mode,
  input  logic [IMM_W-1:0]              in_imm,
  input  logic [DATA_W-1:0]             in_word,
  input  logic [$clog2(DATA_W/8)-1:0]   in_offset,
  input  logic [DATA_W-1:0]             in_rt_old,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_err
);

  logic [DATA_W-1:0] dp_data;
  logic              dp_err;

  logic              main_vld;
  logic [DATA_W-1:0] main_data;
  logic              main_err;
  logic              skid_vld;
  logic [DATA_W-1:0] skid_data;
  logic              skid_err;

  ext_datapath #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_dp (
    .in_mode   (in_mode),
    .in_imm    (in_imm),
    .in_word   (in_word),
    .in_offset (in_offset),
    .in_rt_old (in_rt_old),
    .res_data  (dp_data),
    .res_err   (dp_err)
  );

  assign in_ready  = !skid_vld;
  assign out_valid = main_vld;
  assign out_data  = main_data;
  assign out_err   = main_err;

  // Skid is only ever full while main is full, so refilling main from skid
  // never coincides with an input transfer (in_ready is low then).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld  <= 1'b0;
      main_data <= '0;
      main_err  <= 1'b0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else if (!main_vld || out_ready) begin
      if (skid_vld) begin
        main_vld  <= 1'b1;
        main_data <= skid_data;
        main_err  <= skid_err;
        skid_vld  <= 1'b0;
      end else if (in_valid) begin
        main_vld  <= 1'b1;
        main_data <= dp_data;
        main_err  <= dp_err;
      end else begin
        main_vld  <= 1'b0;
      end
    end else if (in_valid && !skid_vld) begin
      skid_vld  <= 1'b1;
      skid_data <= dp_data;
      skid_err  <= dp_err;
    end
  end

endmodule

// File: tb/tb_data_extender.sv
// Bench for data_extender: directed vector table, backpressure/reset sequences, random vs byte-level model.
module tb_data_extender;
  import mips_ext_pkg::*;

  localparam int DW = 32;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_mode = 4'd0;
  logic [IW-1:0] in_imm = '0;
  logic [DW-1:0] in_word = '0;
  logic [1:0]    in_offset = '0;
  logic [DW-1:0] in_rt_old = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_err;

  always #5 clk = ~clk;

  data_extender #(.DATA_W(DW), .IMM_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_imm    (in_imm),
    .in_word   (in_word),
    .in_offset (in_offset),
    .in_rt_old (in_rt_old),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } res_t;

  res_t        q[$];
  logic [31:0] dut_seen[$];

  typedef struct {
    string       name;
    logic [3:0]  mode;
    logic [15:0] imm;
    logic [31:0] word;
    logic [1:0]  off;
    logic [31:0] rt;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-lane reference: builds results lane by lane from the architectural rules.
  function automatic res_t ref_ext(input logic [3:0] mode, input logic [15:0] imm,
                                   input logic [31:0] word, input logic [1:0] off,
                                   input logic [31:0] rt);
    res_t r;
    logic [7:0] wb[4];
    logic [7:0] rb[4];
    logic [7:0] ob[4];
    int k;
    int h;
    k = int'(off);
    for (int i = 0; i < 4; i++) begin
      wb[i] = word[8*i +: 8];
      rb[i] = rt[8*i +: 8];
      ob[i] = 8'h00;
    end
    r.err  = 1'b0;
    r.data = 32'h0;
    case (mode)
      4'd0: begin
        r.data = 32'(imm);
        if (imm >= 16'h8000) r.data = r.data + 32'hFFFF0000;
      end
      4'd1: r.data = 32'(imm);
      4'd2: r.data = 32'(imm) * 32'h10000;
      4'd3, 4'd4: begin
        r.data = 32'(wb[k]);
        if (mode == 4'd3 && wb[k] >= 8'h80) r.data = r.data + 32'hFFFFFF00;
      end
      4'd5, 4'd6: begin
        if (k % 2 == 1) r.err = 1'b1;
        else begin
          h = int'(wb[k]) + 256 * int'(wb[k+1]);
          r.data = 32'(h);
          if (mode == 4'd5 && h >= 32768) r.data = r.data + 32'hFFFF0000;
        end
      end
      4'd7: begin
        if (k != 0) r.err = 1'b1;
        else r.data = word;
      end
      4'd8, 4'd9: begin
        for (int i = 0; i < 4; i++) begin
          if (mode == 4'd8) ob[i] = (i >= 3 - k) ? wb[i - (3 - k)] : rb[i];
          else              ob[i] = (i <= 3 - k) ? wb[i + k] : rb[i];
          r.data = r.data + (32'(ob[i]) << (8 * i));
        end
      end
      default: r.err = 1'b1;
    endcase
    if (r.err) r.data = 32'h0;
    return r;
  endfunction

  // One clock: check outputs against the model, drive inputs, advance, update model.
  task automatic cyc(input logic v, input logic [3:0] m, input logic [15:0] imm,
                     input logic [31:0] w, input logic [1:0] off, input logic [31:0] rt,
                     input logic ordy);
    logic exp_rdy;
    logic in_x;
    logic out_x;
    exp_rdy = (q.size() < 2);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("out_data", out_data, q[0].data);
      check("out_err", 32'(out_err), 32'(q[0].err));
    end
    in_valid  = v;
    in_mode   = m;
    in_imm    = imm;
    in_word   = w;
    in_offset = off;
    in_rt_old = rt;
    out_ready = ordy;
    in_x  = v && exp_rdy;
    out_x = (q.size() > 0) && ordy;
    if (out_x) dut_seen.push_back(out_data);
    @(posedge clk);
    #1;
    if (out_x) void'(q.pop_front());
    if (in_x) q.push_back(ref_ext(m, imm, w, off, rt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 16'h0, 32'h0, 2'd0, 32'h0, 1'b1);
  endtask

  initial begin
    vecs[0]  = '{"simm",   4'd0, 16'h8001, 32'h0,        2'd0, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[1]  = '{"zimm",   4'd1, 16'h8001, 32'h0,        2'd0, 32'h0,        32'h00008001, 1'b0};
    vecs[2]  = '{"lui",    4'd2, 16'h8001, 32'h0,        2'd0, 32'h0,        32'h80010000, 1'b0};
    vecs[3]  = '{"lb3",    4'd3, 16'h0,    32'h80FF7F01, 2'd3, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[4]  = '{"lbu3",   4'd4, 16'h0,    32'h80FF7F01, 2'd3, 32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{"lh2",    4'd5, 16'h0,    32'h80FF7F01, 2'd2, 32'h0,        32'hFFFF80FF, 1'b0};
    vecs[6]  = '{"lhu0",   4'd6, 16'h0,    32'h80FF7F01, 2'd0, 32'h0,        32'h00007F01, 1'b0};
    vecs[7]  = '{"lwl1",   4'd8, 16'h0,    32'hAABBCCDD, 2'd1, 32'h11223344, 32'hCCDD3344, 1'b0};
    vecs[8]  = '{"lwr1",   4'd9, 16'h0,    32'hAABBCCDD, 2'd1, 32'h11223344, 32'h11AABBCC, 1'b0};
    vecs[9]  = '{"lwl3",   4'd8, 16'h0,    32'hAABBCCDD, 2'd3, 32'h11223344, 32'hAABBCCDD, 1'b0};
    vecs[10] = '{"lwl0",   4'd8, 16'h0,    32'hAABBCCDD, 2'd0, 32'h11223344, 32'hDD223344, 1'b0};
    vecs[11] = '{"lwr3",   4'd9, 16'h0,    32'hAABBCCDD, 2'd3, 32'h11223344, 32'h112233AA, 1'b0};
    vecs[12] = '{"lw0",    4'd7, 16'h0,    32'h12345678, 2'd0, 32'h0,        32'h12345678, 1'b0};
    vecs[13] = '{"lh1err", 4'd5, 16'h0,    32'h80FF7F01, 2'd1, 32'h0,        32'h00000000, 1'b1};
    vecs[14] = '{"lw2err", 4'd7, 16'h0,    32'h12345678, 2'd2, 32'h0,        32'h00000000, 1'b1};
    vecs[15] = '{"modeF",  4'hF, 16'hFFFF, 32'hFFFFFFFF, 2'd0, 32'hFFFFFFFF, 32'h00000000, 1'b1};

    // Reset state, observed without any clock edge
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table, one transaction per cycle, consumer always ready
    foreach (vecs[i]) begin
      cyc(1'b1, vecs[i].mode, vecs[i].imm, vecs[i].word, vecs[i].off, vecs[i].rt, 1'b1);
      in_valid = 1'b0;
      check({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
      check({vecs[i].name, "_data"}, out_data, vecs[i].exp_data);
      check({vecs[i].name, "_err"}, 32'(out_err), 32'(vecs[i].exp_err));
    end
    idle(2);

    // Backpressure: three offers while stalled, two accepted, order preserved
    dut_seen.delete();
    cyc(1'b1, 4'd1, 16'h0001, 32'h0, 2'd0, 32'h0, 1'b0);
    cyc(1'b1, 4'd1, 16'h0002, 32'h0, 2'd0, 32'h0, 1'b0);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    cyc(1'b1, 4'd1, 16'h0003, 32'h0, 2'd0, 32'h0, 1'b0);
    check("bp_hold_data", out_data, 32'h1);
    check("bp_still_full", 32'(in_ready), 32'd0);
    cyc(1'b1, 4'd1, 16'h0003, 32'h0, 2'd0, 32'h0, 1'b1);
    cyc(1'b1, 4'd1, 16'h0003, 32'h0, 2'd0, 32'h0, 1'b1);
    idle(3);
    check("bp_count", 32'(dut_seen.size()), 32'd3);
    for (int i = 0; i < 3 && i < dut_seen.size(); i++)
      check("bp_order", dut_seen[i], 32'(i + 1));

    // Reset with both entries full: stale results must vanish
    cyc(1'b1, 4'd1, 16'hAAAA, 32'h0, 2'd0, 32'h0, 1'b0);
    cyc(1'b1, 4'd1, 16'hBBBB, 32'h0, 2'd0, 32'h0, 1'b0);
    check("rst2_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd1);
    check("rst2_out_data", out_data, 32'h0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_no_stale", 32'(out_valid), 32'd0);
    cyc(1'b1, 4'd1, 16'h0055, 32'h0, 2'd0, 32'h0, 1'b1);
    in_valid = 1'b0;
    check("rst2_new_data", out_data, 32'h55);
    idle(2);

    // Random traffic against the byte-level model
    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom_range(0, 9) < 7),
          4'($urandom_range(0, 11)),
          16'($urandom),
          32'($urandom),
          2'($urandom_range(0, 3)),
          32'($urandom),
          1'($urandom_range(0, 9) < 6));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_extender.md
DATA_EXTENDER -- requirements
Module: data_extender

Interface
REQ-001 Parameter DATA_W, default 32: datapath width in bits; SHALL be a multiple of 8 and at least 2*IMM_W.
REQ-002 Parameter IMM_W, default 16: immediate field width in bits.
REQ-003 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1: input transaction present.
REQ-006 Port in_ready  output  1: block can accept an input this cycle.
REQ-007 Port in_mode  input  4: ext_mode_t operation select.
REQ-008 Port in_imm  input  IMM_W: immediate operand.
REQ-009 Port in_word  input  DATA_W: memory read word, little-endian byte lanes.
REQ-010 Port in_offset  input  clog2(DATA_W/8): byte address low bits.
REQ-011 Port in_rt_old  input  DATA_W: previous rt value, used by LWL/LWR merge.
REQ-012 Port out_valid  output  1: result present.
REQ-013 Port out_ready  input  1: consumer accepts the result.
REQ-014 Port out_data  output  DATA_W: extended result.
REQ-015 Port out_err  output  1: misaligned access or illegal mode.

Function
REQ-016 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-017 Latency SHALL be 1 cycle: a result SHALL appear on out_data the cycle after its input transfer when the output stage is empty or draining.
REQ-018 Storage SHALL be a 2-entry skid buffer (main + skid) so in_ready depends only on registered state, never combinationally on out_ready.
REQ-019 in_ready SHALL be 1 iff the skid entry is empty.
REQ-020 When out_valid && !out_ready and an input transfers, the new result SHALL go to skid; the main entry SHALL be held unchanged.
REQ-021 When the main entry drains and skid is full, skid SHALL move to main in the same edge; results SHALL leave in input order, with none lost or duplicated.
REQ-022 With both entries full, simultaneous output and input transfers SHALL NOT occur, because in_ready is 0.
REQ-023 out_data and out_err SHALL be stable while out_valid && !out_ready.
REQ-024 EXT_SIMM: out_data SHALL be in_imm sign-extended to DATA_W.
REQ-025 EXT_ZIMM: out_data SHALL be in_imm zero-extended.
REQ-026 EXT_LUI: out_data SHALL be in_imm placed at bits [2*IMM_W-1:IMM_W], with zeros elsewhere.
REQ-027 EXT_LB/EXT_LBU: the byte at lane in_offset SHALL be sign- or zero-extended.
REQ-028 EXT_LH/EXT_LHU: the halfword at lanes in_offset and in_offset+1 SHALL be sign- or zero-extended.
REQ-029 EXT_LH/EXT_LHU with in_offset[0]=1 SHALL set out_err=1.
REQ-030 EXT_LW: out_data SHALL equal in_word.
REQ-031 EXT_LW with in_offset≠0 SHALL set out_err=1.
REQ-032 EXT_LWL, offset k, L=DATA_W/8: out_data = (in_word << 8*(L-1-k)) | (in_rt_old & low 8*(L-1-k) bits mask).
REQ-033 EXT_LWR, offset k: out_data = (in_word >> 8k) | (in_rt_old & high 8k bits mask).
REQ-034 Any unlisted in_mode code SHALL set out_err=1.
REQ-035 Whenever out_err=1, out_data SHALL be 0.
REQ-036 Inputs SHALL be ignored when no input transfer occurs.

Reset
REQ-037 While rst_n=0, out_valid=0, out_data=0, out_err=0, in_ready=1, and both buffer entries SHALL be empty, immediately and without a clock.
REQ-038 A reset asserted mid-operation SHALL discard all buffered results; the first input after deassertion SHALL be treated as new.

Structure
REQ-039 Package mips_ext_pkg SHALL hold ext_mode_t (SIMM=0, ZIMM=1, LUI=2, LB=3, LBU=4, LH=5, LHU=6, LW=7, LWL=8, LWR=9) and default width constants.
REQ-040 The combinational extension/merge function SHALL be a sub-module ext_datapath, instantiated once ahead of the skid buffer.

Verification
REQ-041 SIMM in_imm=16'h8001 -> out_data=32'hFFFF8001 one cycle later; ZIMM -> 32'h00008001; LUI -> 32'h80010000.
REQ-042 LB, in_word=32'h80FF7F01, offset=3 -> 32'hFFFFFF80; LBU same -> 32'h00000080; LH offset=2 -> 32'hFFFF80FF.
REQ-043 LWL offset=1, in_word=32'hAABBCCDD, rt_old=32'h11223344 -> 32'hCCDD3344; LWR offset=1 -> 32'h11AABBCC.
REQ-044 LH offset=1, LW offset=2, and in_mode=4'hF -> out_err=1, out_data=0 each.
REQ-045 out_ready held 0 for 3 cycles while 3 inputs are offered -> 2 accepted, in_ready=0 after the second; release -> results in order, no loss.
REQ-046 rst_n pulsed low with both entries full -> out_valid=0 and in_ready=1 immediately; the stale results SHALL never appear.
